// File: rtl/lcd_text_driver.sv
// ----------------------------------------------------------------------------
// lcd_text_driver
//
// Drives an HD44780-compatible character LCD (2 x 16) in 4-bit mode.
// After power-up it waits T_PWRUP cycles and sends the 4-bit init nibbles
// 3,3,3,2. It then sends the configuration bytes 28,06,0C,01 and parks in
// IDLE. A refresh request snapshots the 32-character frame and writes it out
// as: address 0x80, 16 chars of line 1, address 0xC0, 16 chars of line 2.
//
// Build option:
//   LCD_CLEAR_ON_REFRESH_EN - when defined, every refresh first sends a clear
//                             command (0x01) and waits T_CLR before 0x80.
//
// Parameters (all in clk cycles):
//   T_PWRUP  power-on wait before the first init nibble
//   T_EHI    lcd_e high time, also the data setup time before E rises
//   T_NIB    gap between the high and low nibble of one byte
//   T_CMD    wait after each byte or init nibble
//   T_CLR    wait after the clear command 0x01
//
// Ports:
//   clk      clock, rising edge
//   rst_n    synchronous active-low reset
//   cls      refresh request, level-sampled every cycle
//   strdata  32 ASCII chars; line 1 = [255:128], line 2 = [127:0], leftmost
//            char in the MSBs
//   lcd_e    enable strobe (registered)
//   lcd_rs   register select, 0 = command, 1 = data
//   lcd_rw   read/write, always 0 (write only)
//   lcd_dat  4-bit data nibble
//   busy     high whenever the controller is not in IDLE
// ----------------------------------------------------------------------------
module lcd_text_driver #(
    parameter int T_PWRUP = 750000,
    parameter int T_EHI   = 12,
    parameter int T_NIB   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cls,
    input  logic [255:0] strdata,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [3:0]   lcd_dat,
    output logic         busy
);

    // Terminal counts: a phase of length N ends when the counter reads N-1.
    localparam logic [31:0] LAST_PWRUP = 32'(T_PWRUP - 1);
    localparam logic [31:0] LAST_EHI   = 32'(T_EHI - 1);
    localparam logic [31:0] LAST_NIB   = 32'(T_NIB - 1);
    localparam logic [31:0] LAST_CMD   = 32'(T_CMD - 1);
    localparam logic [31:0] LAST_CLR   = 32'(T_CLR - 1);

    typedef enum logic [3:0] {
        S_PWR_WAIT = 4'd0,
        S_INIT     = 4'd1,
        S_CFG      = 4'd2,
        S_IDLE     = 4'd3,
`ifdef LCD_CLEAR_ON_REFRESH_EN
        S_CLR      = 4'd4,
`endif
        S_ADDR1    = 4'd5,
        S_LINE1    = 4'd6,
        S_ADDR2    = 4'd7,
        S_LINE2    = 4'd8
    } state_t;

    // Phases of one transfer. Init nibbles skip GAP/SU_LO/E_LO.
    typedef enum logic [2:0] {
        P_SU_HI = 3'd0,   // high nibble driven, E low (setup)
        P_E_HI  = 3'd1,   // E high, high nibble
        P_GAP   = 3'd2,   // E low between nibbles
        P_SU_LO = 3'd3,   // low nibble driven, E low (setup)
        P_E_LO  = 3'd4,   // E high, low nibble
        P_WAIT  = 3'd5    // execution wait after the transfer
    } phase_t;

    state_t        state_reg,   state_next;
    phase_t        phase_reg,   phase_next;
    logic [31:0]   cnt_reg,     cnt_next;
    logic [3:0]    idx_reg,     idx_next;
    logic          pending_reg, pending_next;
    logic [255:0]  snap_reg,    snap_next;
    logic          e_reg,       e_next;
    logic          rs_reg,      rs_next;
    logic [3:0]    dat_reg,     dat_next;

    logic          byte_done;
    logic [31:0]   phase_last;
    logic [7:0]    cur_byte;
    logic          cur_rs;
    logic [7:0]    next_byte;

    // Character view of the snapshot: chars[0..15] = line 1, chars[16..31] =
    // line 2, each left to right.
    logic [7:0]    chars [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_chars
            assign chars[gi] = snap_reg[255 - 8*gi -: 8];
        end
    endgenerate

    // Byte (or, in INIT, nibble placed in the upper half) sent in a state.
    function automatic logic [7:0] byte_of(
        input state_t     st,
        input logic [3:0] idx,
        input logic [7:0] ch1,
        input logic [7:0] ch2
    );
        logic [7:0] b;
        b = 8'h00;
        case (st)
            S_INIT:  b = (idx == 4'd3) ? 8'h20 : 8'h30;
            S_CFG: begin
                case (idx[1:0])
                    2'd0:    b = 8'h28;
                    2'd1:    b = 8'h06;
                    2'd2:    b = 8'h0C;
                    default: b = 8'h01;
                endcase
            end
`ifdef LCD_CLEAR_ON_REFRESH_EN
            S_CLR:   b = 8'h01;
`endif
            S_ADDR1: b = 8'h80;
            S_LINE1: b = ch1;
            S_ADDR2: b = 8'hC0;
            S_LINE2: b = ch2;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // State register (also holds the registered LCD outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_PWR_WAIT;
            phase_reg   <= P_WAIT;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            pending_reg <= 1'b0;
            snap_reg    <= '0;
            e_reg       <= 1'b0;
            rs_reg      <= 1'b0;
            dat_reg     <= 4'h0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
            snap_reg    <= snap_next;
            e_reg       <= e_next;
            rs_reg      <= rs_next;
            dat_reg     <= dat_next;
        end
    end

    // Byte currently in flight; the clear command gets the long wait. Data
    // bytes never do, even if a character happens to be 0x01.
    assign cur_byte = byte_of(state_reg, idx_reg,
                              chars[{1'b0, idx_reg}], chars[{1'b1, idx_reg}]);
    assign cur_rs   = (state_reg == S_LINE1) || (state_reg == S_LINE2);

    always_comb begin
        phase_last = LAST_EHI;
        case (phase_reg)
            P_GAP:   phase_last = LAST_NIB;
            P_WAIT:  phase_last = (cur_byte == 8'h01 && !cur_rs) ? LAST_CLR : LAST_CMD;
            default: phase_last = LAST_EHI;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        cnt_next     = cnt_reg + 32'd1;
        idx_next     = idx_reg;
        pending_next = pending_reg;
        snap_next    = snap_reg;
        byte_done    = 1'b0;

        case (state_reg)
            S_PWR_WAIT: begin
                if (cnt_reg == LAST_PWRUP) begin
                    state_next = S_INIT;
                    phase_next = P_SU_HI;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end

            S_IDLE: begin
                cnt_next = '0;
                if (cls || pending_reg) begin
                    // Frame is frozen here; later strdata changes are ignored
                    // until the next refresh.
                    snap_next    = strdata;
                    pending_next = 1'b0;
                    phase_next   = P_SU_HI;
                    idx_next     = '0;
`ifdef LCD_CLEAR_ON_REFRESH_EN
                    state_next   = S_CLR;
`else
                    state_next   = S_ADDR1;
`endif
                end
            end

            default: begin
                // Transfer sequencer shared by all sending states.
                if (cnt_reg == phase_last) begin
                    cnt_next = '0;
                    case (phase_reg)
                        P_SU_HI: phase_next = P_E_HI;
                        P_E_HI:  phase_next = (state_reg == S_INIT) ? P_WAIT : P_GAP;
                        P_GAP:   phase_next = P_SU_LO;
                        P_SU_LO: phase_next = P_E_LO;
                        P_E_LO:  phase_next = P_WAIT;
                        default: begin
                            phase_next = P_SU_HI;
                            byte_done  = 1'b1;
                        end
                    endcase
                end

                if (byte_done) begin
                    case (state_reg)
                        S_INIT: begin
                            idx_next = idx_reg + 4'd1;
                            if (idx_reg == 4'd3) begin
                                state_next = S_CFG;
                                idx_next   = '0;
                            end
                        end
                        S_CFG: begin
                            idx_next = idx_reg + 4'd1;
                            if (idx_reg == 4'd3) begin
                                state_next = S_IDLE;
                                idx_next   = '0;
                            end
                        end
`ifdef LCD_CLEAR_ON_REFRESH_EN
                        S_CLR: begin
                            state_next = S_ADDR1;
                        end
`endif
                        S_ADDR1: begin
                            state_next = S_LINE1;
                            idx_next   = '0;
                        end
                        // The 4-bit index rolls 15 -> 0 on the same edge that
                        // moves on to the next address command.
                        S_LINE1: begin
                            idx_next = idx_reg + 4'd1;
                            if (idx_reg == 4'd15) begin
                                state_next = S_ADDR2;
                            end
                        end
                        S_ADDR2: begin
                            state_next = S_LINE2;
                            idx_next   = '0;
                        end
                        S_LINE2: begin
                            idx_next = idx_reg + 4'd1;
                            if (idx_reg == 4'd15) begin
                                state_next = S_IDLE;
                            end
                        end
                        default: begin
                            state_next = S_PWR_WAIT;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end
        endcase

        // Requests arriving while busy collapse into a single pending refresh.
        if (cls && (state_reg != S_IDLE)) begin
            pending_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: decoded from the next state so the registered outputs line
    // up exactly with the phase they belong to.
    // ------------------------------------------------------------------------
    assign next_byte = byte_of(state_next, idx_next,
                               chars[{1'b0, idx_next}], chars[{1'b1, idx_next}]);

    always_comb begin
        e_next   = 1'b0;
        rs_next  = 1'b0;
        dat_next = 4'h0;
        if ((state_next != S_PWR_WAIT) && (state_next != S_IDLE)) begin
            rs_next = (state_next == S_LINE1) || (state_next == S_LINE2);
            e_next  = (phase_next == P_E_HI) || (phase_next == P_E_LO);
            // Each nibble is held after E falls, so data only ever changes
            // while E is low.
            if (state_next == S_INIT) begin
                dat_next = next_byte[7:4];
            end else begin
                case (phase_next)
                    P_SU_HI, P_E_HI, P_GAP: dat_next = next_byte[7:4];
                    default:                dat_next = next_byte[3:0];
                endcase
            end
        end
    end

    assign lcd_e   = e_reg;
    assign lcd_rs  = rs_reg;
    assign lcd_dat = dat_reg;
    assign lcd_rw  = 1'b0;
    assign busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_lcd_text_driver.sv
// ----------------------------------------------------------------------------
// Testbench for lcd_text_driver. A bus monitor records every lcd_e pulse
// (rs, nibble, width, rise cycle). Each scenario task builds the expected
// byte stream from the frame text and compares it with the recorded pulses.
// ----------------------------------------------------------------------------
module tb_lcd_text_driver;

    localparam int T_PWRUP = 100;
    localparam int T_EHI   = 2;
    localparam int T_NIB   = 3;
    localparam int T_CMD   = 10;
    localparam int T_CLR   = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cls = 1'b0;
    logic [255:0] strdata = '0;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [3:0]   lcd_dat;
    logic         busy;

    lcd_text_driver #(
        .T_PWRUP (T_PWRUP),
        .T_EHI   (T_EHI),
        .T_NIB   (T_NIB),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cls     (cls),
        .strdata (strdata),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_dat (lcd_dat),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus monitor ----------------
    typedef struct {
        bit       rs;
        bit [3:0] dat;
        int       width;
        int       rise;
    } pulse_t;

    pulse_t   pulse_q[$];
    pulse_t   cur_p;
    bit       e_prev = 1'b0;
    int       stab_err = 0;
    int       rw_err = 0;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_err++;
        if (lcd_e === 1'b1 && !e_prev) begin
            cur_p.rs    = lcd_rs;
            cur_p.dat   = lcd_dat;
            cur_p.width = 1;
            cur_p.rise  = cyc;
        end else if (lcd_e === 1'b1) begin
            cur_p.width++;
            if (lcd_rs !== cur_p.rs || lcd_dat !== cur_p.dat) stab_err++;
        end else if (e_prev) begin
            pulse_q.push_back(cur_p);
        end
        e_prev = (lcd_e === 1'b1);
    end

    // ---------------- reference model ----------------
    logic [3:0] init_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2,
                                  4'h2, 4'h8, 4'h0, 4'h6,
                                  4'h0, 4'hC, 4'h0, 4'h1};
    logic [8:0] exp_q[$];   // {rs, byte}

    task automatic build_expect(input logic [255:0] s);
        logic [127:0] ln;
        exp_q.delete();
`ifdef LCD_CLEAR_ON_REFRESH_EN
        exp_q.push_back(9'h001);
`endif
        exp_q.push_back(9'h080);
        ln = s[255:128];
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({1'b1, ln[127:120]});
            ln = ln << 8;
        end
        exp_q.push_back(9'h0C0);
        ln = s[127:0];
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({1'b1, ln[127:120]});
            ln = ln << 8;
        end
    endtask

    function automatic logic [255:0] rand_text();
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    // Compare recorded pulses of one refresh with exp_q.
    task automatic check_refresh(input string tag, input int t_idle);
        logic [8:0] got;
        int bad_t;
        int min_gap;
        int n;
        n = exp_q.size();
        checks++;
        if (pulse_q.size() != 2 * n) begin
            failures++;
            $display("FAIL %s pulse_count actual=%0d required=%0d", tag, pulse_q.size(), 2 * n);
        end else begin
            bad_t = 0;
            for (int i = 0; i < n; i++) begin
                got = {pulse_q[2*i].rs, pulse_q[2*i].dat, pulse_q[2*i+1].dat};
                checks++;
                if (got !== exp_q[i] || pulse_q[2*i].rs !== pulse_q[2*i+1].rs) begin
                    failures++;
                    $display("FAIL %s byte%0d actual={rs,byte}=%h required=%h", tag, i, got, exp_q[i]);
                end
                if (pulse_q[2*i].width != T_EHI || pulse_q[2*i+1].width != T_EHI) bad_t++;
                if (pulse_q[2*i+1].rise - pulse_q[2*i].rise < 2*T_EHI + T_NIB) bad_t++;
                if (i + 1 < n) begin
                    min_gap = (exp_q[i] == 9'h001) ? 2*T_EHI + T_CLR : 2*T_EHI + T_CMD;
                    if (pulse_q[2*i+2].rise - pulse_q[2*i+1].rise < min_gap) bad_t++;
                end
            end
            checks++;
            if (bad_t != 0) begin
                failures++;
                $display("FAIL %s strobe_timing violations actual=%0d required=0", tag, bad_t);
            end
            checks++;
            if (t_idle - pulse_q[2*n-1].rise < T_EHI + T_CMD) begin
                failures++;
                $display("FAIL %s busy_fall actual=%0d required>=%0d", tag,
                         t_idle - pulse_q[2*n-1].rise, T_EHI + T_CMD);
            end
        end
        $display("refresh %s: %0d pulses for %0d bytes", tag, pulse_q.size(), n);
    endtask

    // Compare recorded pulses of a power-up sequence.
    task automatic check_init(input string tag, input int t_rel, input int t_idle);
        int bad_t;
        checks++;
        if (pulse_q.size() != 12) begin
            failures++;
            $display("FAIL %s init_pulse_count actual=%0d required=12", tag, pulse_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (pulse_q[i].dat !== init_nib[i] || pulse_q[i].rs !== 1'b0) begin
                    failures++;
                    $display("FAIL %s init_nibble%0d actual=rs%0d/%h required=rs0/%h", tag, i,
                             pulse_q[i].rs, pulse_q[i].dat, init_nib[i]);
                end
            end
            checks++;
            if (pulse_q[0].rise - t_rel < T_PWRUP) begin
                failures++;
                $display("FAIL %s first_strobe actual=%0d required>=%0d", tag,
                         pulse_q[0].rise - t_rel, T_PWRUP);
            end
            bad_t = 0;
            for (int i = 0; i < 12; i++) if (pulse_q[i].width != T_EHI) bad_t++;
            for (int i = 0; i < 4; i++)
                if (pulse_q[i+1].rise - pulse_q[i].rise < 2*T_EHI + T_CMD) bad_t++;
            checks++;
            if (bad_t != 0) begin
                failures++;
                $display("FAIL %s init_timing violations actual=%0d required=0", tag, bad_t);
            end
            checks++;
            if (t_idle - pulse_q[11].rise < T_EHI + T_CLR) begin
                failures++;
                $display("FAIL %s clear_wait actual=%0d required>=%0d", tag,
                         t_idle - pulse_q[11].rise, T_EHI + T_CLR);
            end
        end
        $display("init %s: %0d pulses, idle at cycle %0d", tag, pulse_q.size(), t_idle);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit ok;
        int at;
        int t_rel;
        rst_n = 1'b0;
        cls = 1'b0;
        repeat (3) tick();
        checks++; if (lcd_e !== 1'b0)   begin failures++; $display("FAIL reset_e actual=%b required=0", lcd_e); end
        checks++; if (lcd_rs !== 1'b0)  begin failures++; $display("FAIL reset_rs actual=%b required=0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0)  begin failures++; $display("FAIL reset_rw actual=%b required=0", lcd_rw); end
        checks++; if (lcd_dat !== 4'h0) begin failures++; $display("FAIL reset_dat actual=%h required=0", lcd_dat); end
        checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL reset_busy actual=%b required=1", busy); end
        pulse_q.delete();
        rst_n = 1'b1;
        t_rel = cyc;
        repeat (T_PWRUP) tick();
        checks++;
        if (pulse_q.size() != 0 || lcd_e !== 1'b0) begin
            failures++;
            $display("FAIL pwrup_quiet actual=%0d pulses required=0", pulse_q.size());
        end
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL init_timeout actual=busy required=idle"); end
        check_init("reset", t_rel, at);
    endtask

    task automatic test_refresh_fixed();
        bit ok;
        int at;
        strdata[255:128] = "0123456789ABCDEF";
        strdata[127:0]   = "HELLO WORLD     ";
        build_expect(strdata);
        pulse_q.delete();
        cls = 1'b1;
        tick();
        cls = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL refresh_start actual=%b required=1", busy); end
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL refresh_timeout actual=busy required=idle"); end
        check_refresh("fixed", at);
    endtask

    task automatic test_snapshot();
        bit ok;
        int at;
        bit seen;
        for (int r = 0; r < 2; r++) begin
            strdata = rand_text();
            build_expect(strdata);
            pulse_q.delete();
            cls = 1'b1;
            tick();
            cls = 1'b0;
            strdata = rand_text();
            seen = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (pulse_q.size() >= 10) begin seen = 1'b1; break; end
                tick();
            end
            strdata = rand_text();
            checks++;
            if (!seen) begin failures++; $display("FAIL snapshot_line1_timeout actual=%0d pulses required>=10", pulse_q.size()); end
            wait_idle(3000, ok, at);
            checks++;
            if (!ok) begin failures++; $display("FAIL snapshot_timeout actual=busy required=idle"); end
            check_refresh($sformatf("snapshot%0d", r), at);
        end
    endtask

    task automatic test_coalesce();
        bit ok;
        int at;
        logic [255:0] b_text;
        strdata = rand_text();
        build_expect(strdata);
        pulse_q.delete();
        cls = 1'b1;
        tick();
        cls = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(20, 80)) tick();
            strdata = rand_text();
            cls = 1'b1;
            tick();
            cls = 1'b0;
        end
        b_text = rand_text();
        strdata = b_text;
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL coalesce_timeout1 actual=busy required=idle"); end
        check_refresh("coalesce_first", at);
        build_expect(b_text);
        pulse_q.delete();
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL coalesce_restart actual=%b required=1", busy); end
        strdata = rand_text();
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL coalesce_timeout2 actual=busy required=idle"); end
        check_refresh("coalesce_second", at);
        pulse_q.delete();
        repeat (60) tick();
        checks++;
        if (busy !== 1'b0 || pulse_q.size() != 0) begin
            failures++;
            $display("FAIL coalesce_extra actual=busy%b/%0d pulses required=idle/0", busy, pulse_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int at;
        strdata = rand_text();
        build_expect(strdata);
        pulse_q.delete();
        cls = 1'b1;
        tick();
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_timeout1 actual=busy required=idle"); end
        check_refresh("b2b_first", at);
        pulse_q.delete();
        tick();
        cls = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_single_idle actual=%b required=1", busy); end
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_timeout2 actual=busy required=idle"); end
        check_refresh("b2b_second", at);
        repeat (30) tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_stop actual=%b required=0", busy); end
    endtask

    task automatic test_cls_during_init();
        bit ok;
        int at;
        int t_rel;
        logic [255:0] g_text;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        t_rel = cyc;
        pulse_q.delete();
        repeat (10) tick();
        strdata = rand_text();
        cls = 1'b1;
        tick();
        cls = 1'b0;
        repeat (20) tick();
        g_text = rand_text();
        strdata = g_text;
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL early_cls_init_timeout actual=busy required=idle"); end
        check_init("early_cls", t_rel, at);
        build_expect(g_text);
        pulse_q.delete();
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL early_cls_served actual=%b required=1", busy); end
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL early_cls_timeout actual=busy required=idle"); end
        check_refresh("early_cls", at);
    endtask

    task automatic test_reset_mid_strobe();
        bit ok;
        bit seen;
        int at;
        int t_rel;
        strdata = rand_text();
        pulse_q.delete();
        cls = 1'b1;
        tick();
        cls = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (pulse_q.size() >= 37 && lcd_e === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL line2_strobe_timeout actual=%0d pulses required>=37", pulse_q.size()); end
        rst_n = 1'b0;
        tick();
        checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL midreset_e actual=%b required=0", lcd_e); end
        checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL midreset_busy actual=%b required=1", busy); end
        checks++;
        if (lcd_rs !== 1'b0 || lcd_dat !== 4'h0) begin
            failures++;
            $display("FAIL midreset_bus actual=rs%b/%h required=rs0/0", lcd_rs, lcd_dat);
        end
        tick();
        rst_n = 1'b1;
        t_rel = cyc;
        pulse_q.delete();
        wait_idle(3000, ok, at);
        checks++;
        if (!ok) begin failures++; $display("FAIL midreset_init_timeout actual=busy required=idle"); end
        check_init("after_midreset", t_rel, at);
        repeat (30) tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset_no_refresh actual=%b required=0", busy); end
    endtask

    task automatic test_bus_stability();
        checks++;
        if (stab_err != 0) begin failures++; $display("FAIL data_stable_under_e actual=%0d required=0", stab_err); end
        checks++;
        if (rw_err != 0) begin failures++; $display("FAIL rw_tied_low actual=%0d required=0", rw_err); end
    endtask

    initial begin
        test_reset();
        test_refresh_fixed();
        test_snapshot();
        test_coalesce();
        test_back_to_back();
        test_cls_during_init();
        test_reset_mid_strobe();
        test_bus_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/lcd_text_driver.md
LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

Interface
REQ-001 Parameter T_PWRUP, default 750000, power-on wait in clk cycles before the first init nibble (15 ms at 50 MHz).
REQ-002 Parameter T_EHI, default 12, lcd_e high time in cycles; T_EHI is also the data setup time before E rises.
REQ-003 Parameter T_NIB, default 50, gap in cycles between the high and low nibble of one byte.
REQ-004 Parameter T_CMD, default 2000, wait in cycles after each byte or init nibble (40 us).
REQ-005 Parameter T_CLR, default 82000, wait in cycles after a clear command, 0x01 (1.64 ms).
REQ-006 clk  in  1  single clock; all logic is on the rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 cls  in  1  refresh request, level-sampled each cycle.
REQ-009 strdata  in  256  32 ASCII chars: line 1 is [255:128], line 2 is [127:0], leftmost char in the MSBs.
REQ-010 lcd_e  out  1  HD44780 enable strobe.
REQ-011 lcd_rs  out  1  register select: 0 = command, 1 = data.
REQ-012 lcd_rw  out  1  read/write select, tied to 0 (write only).
REQ-013 lcd_dat  out  4  data nibble, HD44780 4-bit mode.
REQ-014 busy  out  1  high whenever the FSM is outside IDLE.

Function
REQ-015 The FSM SHALL use these states: PWR_WAIT -> INIT -> CFG -> IDLE -> (CLR) -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> IDLE.
REQ-016 PWR_WAIT SHALL hold for T_PWRUP cycles with lcd_e=0.
REQ-017 INIT SHALL send single nibbles with rs=0, each followed by T_CMD: 0x3, 0x3, 0x3, 0x2.
REQ-018 CFG SHALL send these command bytes: 0x28, 0x06, 0x0C, then 0x01 followed by T_CLR.
REQ-019 The byte-send sequence SHALL be:
- drive rs and the high nibble, wait T_EHI;
- E high for T_EHI, then E low;
- wait T_NIB;
- drive the low nibble, wait T_EHI;
- E high for T_EHI, then E low;
- wait T_CMD (or T_CLR for 0x01).
REQ-020 lcd_dat and lcd_rs SHALL stay stable for the whole interval in which lcd_e=1.
REQ-021 In IDLE, cls=1 SHALL snapshot strdata into an internal 256-bit register on the same edge and leave IDLE on the next cycle.
REQ-022 Display content SHALL come only from the snapshot; strdata changes during a refresh SHALL have no effect on it.
REQ-023 ADDR1 SHALL send command 0x80; LINE1 SHALL send 16 data bytes (rs=1), char i = snapshot[255-8i -: 8].
REQ-024 ADDR2 SHALL send command 0xC0; LINE2 SHALL send 16 data bytes, char i = snapshot[127-8i -: 8].
REQ-025 The char index SHALL be a 4-bit counter that wraps from 15 to 0 exactly on the line transition.
REQ-026 cls=1 seen while busy=1 SHALL set a pending flag; multiple requests SHALL coalesce into one.
REQ-027 On return to IDLE with the pending flag set, the block SHALL start a refresh on the next cycle, snapshot the then-current strdata, and clear the flag.
REQ-028 cls held high continuously SHALL produce back-to-back refreshes with a single IDLE cycle between them.
REQ-029 cls during PWR_WAIT, INIT or CFG SHALL set the pending flag and be served after CFG.
REQ-030 lcd_e SHALL be a registered output.
REQ-031 lcd_rw SHALL be constant 0.

Reset
REQ-032 With rst_n=0 at a clock edge:
- state -> PWR_WAIT;
- lcd_e, lcd_rs and lcd_rw = 0;
- lcd_dat = 4'h0;
- busy = 1;
- pending, counters and snapshot cleared.
REQ-033 A reset mid-refresh or mid-strobe SHALL drop lcd_e to 0 on that edge and restart the full power-up and init sequence.

Configuration
REQ-034 With LCD_CLEAR_ON_REFRESH_EN defined, each refresh SHALL enter CLR (send 0x01, wait T_CLR) before ADDR1.
REQ-035 Without LCD_CLEAR_ON_REFRESH_EN, IDLE SHALL go directly to ADDR1, and CLR logic SHALL be absent.

Verification (T_PWRUP=100, T_EHI=2, T_NIB=3, T_CMD=10, T_CLR=40)
REQ-036 Release reset with cls=0 -> no E pulse for 100 cycles; then 4 single-nibble pulses 3,3,3,2; then bytes 28,06,0C,01; then busy=0.
REQ-037 Idle; strdata line 1 = "0123456789ABCDEF", line 2 = "HELLO WORLD     "; 1-cycle cls pulse ->
- decoded bus stream: 80, 30..39, 41..46, C0, 48 45 4C 4C 4F 20 57 4F 52 4C 44, 5 x 20;
- rs=1 only on data bytes;
- busy falls after the last T_CMD.
REQ-038 Change strdata on the cycle after cls, and again mid-LINE1 -> displayed bytes equal the original snapshot.
REQ-039 Three cls pulses during a refresh -> exactly one further refresh, using strdata as sampled on re-entry to IDLE.
REQ-040 Assert rst_n=0 while lcd_e=1 in LINE2 -> lcd_e=0 on the next edge, then the full init sequence repeats.
REQ-041 With LCD_CLEAR_ON_REFRESH_EN defined -> each refresh starts with byte 01, followed by a 40-cycle wait before 80; without the macro, the first byte is 80.
